// File: rtl/blk_fetch_agu_pkg.sv
// Shared types and geometry for the block-fetch address generator.
// NBR_FETCH_EN adds the top-neighbour row state.
package blk_fetch_pkg;

  localparam int unsigned BLK_N              = 4;
  localparam int unsigned PIX_WID            = 8;
  localparam int unsigned PIC_WID_IN_PIX     = 8192;
  localparam int unsigned PIC_HT_IN_PIX      = 4096;
  localparam int unsigned PIC_WID_IN_BLK     = PIC_WID_IN_PIX / BLK_N;
  localparam int unsigned PIC_HT_IN_BLK      = PIC_HT_IN_PIX / BLK_N;
  localparam int unsigned PIC_WID_IN_BLK_LEN = $clog2(PIC_WID_IN_BLK);
  localparam int unsigned PIC_HT_IN_BLK_LEN  = $clog2(PIC_HT_IN_BLK);
  localparam int unsigned ADDR_WID           = $clog2(PIC_WID_IN_BLK * PIC_HT_IN_PIX) + 1;
  localparam int unsigned ROW_W              = $clog2(BLK_N);
  localparam int unsigned ROW_ADDR_W         = PIC_HT_IN_BLK_LEN + ROW_W;

  localparam int unsigned LUMA_BASE     = 0;
  localparam int unsigned LUMA_STRIDE   = PIC_WID_IN_BLK;
  localparam int unsigned CB_BASE       = 1 << (ADDR_WID - 1);
  localparam int unsigned CR_BASE       = CB_BASE + (1 << (ADDR_WID - 3));
  localparam int unsigned CHROMA_STRIDE = PIC_WID_IN_BLK / 2;

  typedef enum logic [1:0] {
    PL_Y   = 2'd0,
    PL_CB  = 2'd1,
    PL_CR  = 2'd2,
    PL_BAD = 2'd3
  } plane_e;

`ifdef NBR_FETCH_EN
  typedef enum logic [1:0] {IDLE, NBR, ROWS} state_e;
`else
  typedef enum logic [1:0] {IDLE, ROWS} state_e;
`endif

endpackage

// File: rtl/blk_fetch_agu_if.sv
// Coordinate-in / read-request-out bundle of blk_fetch_agu.
interface blk_fetch_agu_if
  import blk_fetch_pkg::*;
();
  logic                          crd_vld;
  logic                          crd_rdy;
  logic [PIC_WID_IN_BLK_LEN-1:0] cor_X;
  logic [PIC_HT_IN_BLK_LEN-1:0]  cor_Y;
  logic [1:0]                    cidx;
  logic                          rd_vld;
  logic                          rd_rdy;
  logic [ADDR_WID-1:0]           rd_addr;
  logic [ROW_W-1:0]              rd_row;
  logic                          rd_last;
  logic                          rd_nbr;
  logic                          avail_top;
  logic                          avail_left;
  logic                          coord_err;

  modport master (
    input  crd_vld, cor_X, cor_Y, cidx, rd_rdy,
    output crd_rdy, rd_vld, rd_addr, rd_row, rd_last, rd_nbr,
           avail_top, avail_left, coord_err
  );

  modport slave (
    output crd_vld, cor_X, cor_Y, cidx, rd_rdy,
    input  crd_rdy, rd_vld, rd_addr, rd_row, rd_last, rd_nbr,
           avail_top, avail_left, coord_err
  );
endinterface

// File: rtl/blk_fetch_agu_row_addr.sv
// Word address of one pixel row of a block: plane base + row*stride + column.
module blk_row_addr
  import blk_fetch_pkg::*;
(
  input  plane_e                        cidx,
  input  logic [PIC_WID_IN_BLK_LEN-1:0] x,
  input  logic [ROW_ADDR_W-1:0]         r,
  output logic [ADDR_WID-1:0]           addr
);
  // Strides are powers of two, so row*stride+x is just {r, x}; chroma drops one bit of each.
  always_comb begin
    case (cidx)
      PL_CB:   addr = ADDR_WID'(CB_BASE) |
                      ADDR_WID'({r[ROW_ADDR_W-2:0], x[PIC_WID_IN_BLK_LEN-2:0]});
      PL_CR:   addr = ADDR_WID'(CR_BASE) |
                      ADDR_WID'({r[ROW_ADDR_W-2:0], x[PIC_WID_IN_BLK_LEN-2:0]});
      default: addr = ADDR_WID'(LUMA_BASE) | ADDR_WID'({r, x});
    endcase
  end
endmodule

// File: rtl/blk_fetch_agu.sv
// Block-fetch address generator: one coordinate in, BLK_N row-word reads out.
// NBR_FETCH_EN: prepend a top-neighbour row request when avail_top.
module blk_fetch_agu
  import blk_fetch_pkg::*;
(
  input logic             clk,
  input logic             arst,
  blk_fetch_agu_if.master bus
);
  state_e                        state_q, state_d;
  logic [PIC_WID_IN_BLK_LEN-1:0] x_q, src_x;
  logic [PIC_HT_IN_BLK_LEN-1:0]  y_q, src_y;
  plane_e                        cidx_q, src_c;
  logic                          fire, acc, legal, use_new, upd, vld_d, nbr_d, last_d, err_set;
  logic [ROW_W-1:0]              row_d;
  logic [ROW_ADDR_W-1:0]         r_d;
  logic [ADDR_WID-1:0]           addr_d;

  assign bus.crd_rdy = (state_q == IDLE) | (bus.rd_vld & bus.rd_rdy & bus.rd_last);

  always_comb begin
    state_d = state_q;
    row_d   = bus.rd_row;
    vld_d   = bus.rd_vld;
    nbr_d   = 1'b0;
    use_new = 1'b0;
    upd     = 1'b0;
    err_set = 1'b0;
    fire    = bus.rd_vld & bus.rd_rdy;
    acc     = bus.crd_vld & bus.crd_rdy;

    case (plane_e'(bus.cidx))
      PL_Y:         legal = 1'b1;
      PL_CB, PL_CR: legal = ~bus.cor_X[PIC_WID_IN_BLK_LEN-1] & ~bus.cor_Y[PIC_HT_IN_BLK_LEN-1];
      default:      legal = 1'b0;
    endcase

    if (acc) begin
      if (legal) begin
        use_new = 1'b1;
        upd     = 1'b1;
        vld_d   = 1'b1;
        row_d   = '0;
        state_d = ROWS;
`ifdef NBR_FETCH_EN
        if (bus.cor_Y != '0) begin
          state_d = NBR;
          nbr_d   = 1'b1;
        end
`endif
      end else begin
        err_set = 1'b1;
        vld_d   = 1'b0;
        state_d = IDLE;
      end
    end else if (fire) begin
      if (state_q == ROWS && bus.rd_last) begin
        vld_d   = 1'b0;
        state_d = IDLE;
      end else begin
        upd     = 1'b1;
        row_d   = (state_q == ROWS) ? bus.rd_row + ROW_W'(1) : '0;
        state_d = ROWS;
      end
    end

    // A freshly accepted coordinate must address its first request in the same cycle.
    src_x  = use_new ? bus.cor_X : x_q;
    src_y  = use_new ? bus.cor_Y : y_q;
    src_c  = use_new ? plane_e'(bus.cidx) : cidx_q;
    r_d    = nbr_d ? ({src_y, {ROW_W{1'b0}}} - ROW_ADDR_W'(1)) : {src_y, row_d};
    last_d = ~nbr_d & (row_d == ROW_W'(BLK_N - 1));
  end

  blk_row_addr u_row_addr (
    .cidx (src_c),
    .x    (src_x),
    .r    (r_d),
    .addr (addr_d)
  );

`ifdef NBR_FETCH_EN
  logic nbr_q;
  assign bus.rd_nbr = nbr_q;
  always_ff @(posedge clk or posedge arst) begin
    if (arst)     nbr_q <= 1'b0;
    else if (upd) nbr_q <= nbr_d;
  end
`else
  assign bus.rd_nbr = 1'b0;
`endif

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q        <= IDLE;
      x_q            <= '0;
      y_q            <= '0;
      cidx_q         <= PL_Y;
      bus.rd_vld     <= 1'b0;
      bus.rd_addr    <= '0;
      bus.rd_row     <= '0;
      bus.rd_last    <= 1'b0;
      bus.avail_top  <= 1'b0;
      bus.avail_left <= 1'b0;
      bus.coord_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bus.rd_vld <= vld_d;
      if (err_set) bus.coord_err <= 1'b1;
      if (use_new) begin
        x_q            <= bus.cor_X;
        y_q            <= bus.cor_Y;
        cidx_q         <= plane_e'(bus.cidx);
        bus.avail_top  <= (bus.cor_Y != '0);
        bus.avail_left <= (bus.cor_X != '0);
      end
      if (upd) begin
        bus.rd_addr <= addr_d;
        bus.rd_row  <= row_d;
        bus.rd_last <= last_d;
      end
    end
  end
endmodule

// File: doc/blk_fetch_agu.md
# blk_fetch_agu

Block-fetch address generator sitting directly downstream of the block-coordinate scan FSM. It accepts one block coordinate (cor_X, cor_Y, plane index) per handshake and issues the BLK_N row-word read requests that fetch that block's pixels from frame memory, tagged with row index and neighbour-availability flags for the predictor stage. Luma and the two chroma planes share one linear word-addressed memory.

## Interface
- BLK_N, 4, block edge in pixels; one memory word = BLK_N pixels
- PIX_WID, 8, bits per pixel
- PIC_WID_IN_PIX, 8192, luma picture width (power of two)
- PIC_HT_IN_PIX, 4096, luma picture height (power of two)
- PIC_WID_IN_BLK, PIC_WID_IN_PIX/BLK_N, luma word stride per pixel row
- PIC_WID_IN_BLK_LEN / PIC_HT_IN_BLK_LEN, $clog2 of block-grid width/height
- ADDR_WID, $clog2(PIC_WID_IN_BLK*PIC_HT_IN_PIX)+1, read address width (24 at defaults)

- clk  in  1  clock
- arst  in  1  asynchronous active-high reset
- crd_vld  in  1  coordinate valid
- crd_rdy  out  1  coordinate accepted when crd_vld & crd_rdy
- cor_X  in  PIC_WID_IN_BLK_LEN  block column
- cor_Y  in  PIC_HT_IN_BLK_LEN  block row
- cidx  in  2  plane: 0 luma, 1 Cb, 2 Cr, 3 illegal
- rd_vld  out  1  read request valid
- rd_rdy  in  1  memory accepts request
- rd_addr  out  ADDR_WID  word address
- rd_row  out  2  row within block (0..BLK_N-1)
- rd_last  out  1  final request of the block
- rd_nbr  out  1  request is the top-neighbour row (macro only)
- avail_top / avail_left  out  1 each  cor_Y!=0 / cor_X!=0 of current block
- coord_err  out  1  sticky out-of-range flag

## Operation
- States: IDLE, NBR, ROWS. Reset -> IDLE.
- crd_rdy = (state==IDLE) | (rd_vld & rd_rdy & rd_last); back-to-back blocks at BLK_N requests per block.
- On accept: register X, Y, cidx, avail flags; range check — luma X<PIC_WID_IN_BLK, Y<PIC_HT_IN_PIX/BLK_N; chroma limits halved; cidx==3 illegal. Failing coordinate: coord_err<=1 (sticky until arst), no requests, stay/return IDLE.
- Legal: go NBR if macro on and avail_top, else ROWS with row counter 0.
- Pixel row r = Y*BLK_N + row (NBR: r = Y*BLK_N-1). Address = base + r*stride + X; luma base 0 stride PIC_WID_IN_BLK; Cb base 2^(ADDR_WID-1), stride PIC_WID_IN_BLK/2; Cr base Cb base + 2^(ADDR_WID-3), same stride. All terms power-of-two: concatenation, no multipliers.
- Row counter advances only on rd_vld & rd_rdy; after row BLK_N-1 accepted: next coordinate if accepted same cycle, else IDLE.
- rd_rdy ignored when rd_vld=0.

## Timing
- Coordinate accepted cycle t -> rd_vld=1 at t+1 (registered outputs).
- rd_addr, rd_row, rd_last, rd_nbr, avail_* held stable while rd_vld & !rd_rdy.
- Reset values: rd_vld 0, rd_addr 0, rd_row 0, rd_last 0, rd_nbr 0, avail_top 0, avail_left 0, coord_err 0; crd_rdy 1 after reset released.
- arst mid-block: requests abandoned immediately, no resumption.
- Combinational path rd_rdy -> crd_rdy is intentional.

## Configuration
- NBR_FETCH_EN defined: one extra request for pixel row Y*BLK_N-1 before row 0 when avail_top=1; rd_nbr=1, rd_row=0, rd_last=0 on it. Block with Y=0 skips it.
- Undefined: NBR state absent, rd_nbr tied 0, exactly BLK_N requests per block.

## Structure
- Package blk_fetch_pkg: state enum, cidx plane enum, plane base/stride constants, row-counter width.
- One combinational sub-module blk_row_addr: (cidx, X, r) -> rd_addr; FSM, counter and range check in top.

## Test plan
- Luma X=5,Y=3, rd_rdy=1 -> addresses 24581, 26629, 28677, 30725, rd_last on 4th, avail_top=1, avail_left=1.
- Same with NBR_FETCH_EN -> 22533 (rd_nbr=1) then the four above; Y=0 block -> no neighbour request.
- Cb X=2,Y=0 -> 8388610, 8389634, 8390658, 8391682, avail_top=0.
- rd_rdy low 3 cycles on row 1 -> rd_addr/rd_row unchanged across stall, no row skipped.
- Cb X=1024 or cidx=3 -> coord_err=1, no rd_vld, crd_rdy stays 1; next legal block fetched normally, coord_err stays 1.
- Two coordinates back-to-back with rd_rdy=1 -> 8 consecutive rd_vld cycles; arst during row 2 -> rd_vld=0 immediately, IDLE.
